// File: rtl/brightness_stepper_if.sv
// brightness_stepper_if: pushbutton inputs and duty outputs of the brightness stepper.
// slave is the stepper side, master is the side that owns the buttons and reads the duty.
interface brightness_stepper_if #(
  parameter int W = 4
);
  logic         btn_up;
  logic         btn_dn;
  logic [W-1:0] duty;
  logic         step_pulse;
  logic         at_max;
  logic         at_min;

  modport master (
    output btn_up, btn_dn,
    input  duty, step_pulse, at_max, at_min
  );

  modport slave (
    input  btn_up, btn_dn,
    output duty, step_pulse, at_max, at_min
  );
endinterface

// File: rtl/brightness_stepper.sv
// brightness_stepper: synchronizes and debounces two active-low pushbuttons and
// turns presses into single up/down steps of a W-bit duty register, with
// auto-repeat while a button is held.
// Optional feature macro: BRIGHT_WRAP_EN -- when defined the duty wraps at
// 0 / 2^W-1, otherwise it saturates at the limits.
// The step for a new press is registered on the transition into STEP, so the
// new duty and step_pulse appear together with the STEP state.
module brightness_stepper #(
  parameter int W             = 4,
  parameter int DB_CYCLES     = 500_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int INIT_DUTY     = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  brightness_stepper_if.slave   bus
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int TM_MX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TM_W  = $clog2(TM_MX + 1);

  localparam logic [W-1:0]    MAX_DUTY  = '1;
  localparam logic [W-1:0]    INIT_VAL  = W'(INIT_DUTY);
  localparam logic [DB_W-1:0] DB_LIMIT  = DB_W'(DB_CYCLES);
  localparam logic [TM_W-1:0] HOLD_LIM  = TM_W'(HOLD_CYCLES - 1);
  localparam logic [TM_W-1:0] REP_LIM   = TM_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_HOLD,
    S_REPEAT,
    S_BLOCK
  } state_t;

  // Index 0 = up button, index 1 = down button; all levels active-high.
  logic [1:0]      raw_p0;
  logic [1:0]      raw_p1;
  logic [1:0]      key;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state;
  logic            dir_dn;
  logic [TM_W-1:0] timer;
  logic [W-1:0]    duty_q;
  logic            pulse_q;

  logic            own_key;
  logic            opp_key;
  logic [TM_W-1:0] tmr_lim;

  // One step of the duty register in the requested direction.
  function automatic logic [W-1:0] next_duty(input logic [W-1:0] d, input logic dn);
`ifdef BRIGHT_WRAP_EN
    return dn ? (d - 1'b1) : (d + 1'b1);
`else
    if (dn)
      return (d == '0) ? d : (d - 1'b1);
    else
      return (d == MAX_DUTY) ? d : (d + 1'b1);
`endif
  endfunction

  assign own_key = dir_dn ? key[1] : key[0];
  assign opp_key = dir_dn ? key[0] : key[1];
  assign tmr_lim = (state == S_HOLD) ? HOLD_LIM : REP_LIM;

  // Two-flop synchronizer; buttons are inverted here so pressed = 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_p0 <= '0;
      raw_p1 <= '0;
    end else begin
      raw_p0 <= {~bus.btn_dn, ~bus.btn_up};
      raw_p1 <= raw_p0;
    end
  end

  // Debouncer: the key follows the synchronized level only after it has
  // disagreed for DB_CYCLES+1 consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_p1[i] == key[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LIMIT) begin
          key[i]    <= ~key[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press / hold / repeat / block control with registered duty and pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      dir_dn  <= 1'b0;
      timer   <= '0;
      duty_q  <= INIT_VAL;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key == 2'b11) begin
            state <= S_BLOCK;
          end else if (key != 2'b00) begin
            dir_dn  <= key[1];
            duty_q  <= next_duty(duty_q, key[1]);
            pulse_q <= (next_duty(duty_q, key[1]) != duty_q);
            state   <= S_STEP;
          end
        end
        S_STEP: begin
          timer <= '0;
          state <= S_HOLD;
        end
        S_HOLD, S_REPEAT: begin
          if (opp_key) begin
            state <= S_BLOCK;
          end else if (!own_key) begin
            state <= S_IDLE;
          end else if (timer == tmr_lim) begin
            duty_q  <= next_duty(duty_q, dir_dn);
            pulse_q <= (next_duty(duty_q, dir_dn) != duty_q);
            timer   <= '0;
            state   <= S_REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_BLOCK: begin
          if (key == 2'b00)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.duty       = duty_q;
  assign bus.step_pulse = pulse_q;
  assign bus.at_max     = (duty_q == MAX_DUTY);
  assign bus.at_min     = (duty_q == '0);

endmodule

// File: tb/tb_brightness_stepper.sv
// tb_brightness_stepper: directed scenarios followed by random button activity,
// every cycle compared against a behavioural model of the stepper.
module tb_brightness_stepper;
  localparam int W    = 4;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int MAXD = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic press_up = 1'b0;
  logic press_dn = 1'b0;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_pulse = 0;

  always #5 clk = ~clk;

  brightness_stepper_if #(.W(W)) bus ();

  assign bus.btn_up = ~press_up;
  assign bus.btn_dn = ~press_dn;

  brightness_stepper #(
    .W(W), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .INIT_DUTY(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Model state: duty/pulse, delayed raw levels, debounced keys with the
  // run length of disagreement, and a press tracker (mode/dir/age/due).
  int m_duty  = 0;
  int m_pulse = 0;
  bit lv1 [2];
  bit lv2 [2];
  bit mkey [2];
  int run [2];
  int m_mode = 0;   // 0 waiting for a press, 1 pressed, 2 blocked
  int m_dir  = 1;
  int m_age  = 0;
  int m_due  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int nd;
    nd = m_duty + m_dir;
`ifdef BRIGHT_WRAP_EN
    nd = (nd + MAXD + 1) % (MAXD + 1);
`else
    if (nd < 0) nd = 0;
    if (nd > MAXD) nd = MAXD;
`endif
    m_pulse = (nd != m_duty) ? 1 : 0;
    m_duty  = nd;
  endtask

  task automatic model_edge();
    bit k_up, k_dn, own, opp;
    bit lvl;
    bit pr [2];
    if (!rst_n) begin
      m_duty = 0; m_pulse = 0; m_mode = 0; m_age = 0; m_due = 0; m_dir = 1;
      for (int i = 0; i < 2; i++) begin
        lv1[i] = 0; lv2[i] = 0; mkey[i] = 0; run[i] = 0;
      end
      return;
    end
    m_pulse = 0;
    k_up = mkey[0];
    k_dn = mkey[1];
    if (m_mode == 0) begin
      if (k_up && k_dn) begin
        m_mode = 2;
      end else if (k_up || k_dn) begin
        m_dir = k_dn ? -1 : 1;
        model_step();
        m_mode = 1; m_age = 0; m_due = HOLD + 1;
      end
    end else if (m_mode == 1) begin
      m_age++;
      if (!(m_due == HOLD + 1 && m_age == 1)) begin
        own = (m_dir > 0) ? k_up : k_dn;
        opp = (m_dir > 0) ? k_dn : k_up;
        if (opp) m_mode = 2;
        else if (!own) m_mode = 0;
        else if (m_age == m_due) begin
          model_step();
          m_age = 0; m_due = REP;
        end
      end
    end else begin
      if (!k_up && !k_dn) m_mode = 0;
    end
    pr[0] = press_up;
    pr[1] = press_dn;
    for (int i = 0; i < 2; i++) begin
      lvl    = lv2[i];
      lv2[i] = lv1[i];
      lv1[i] = pr[i];
      if (lvl != mkey[i]) begin
        run[i]++;
        if (run[i] == DB + 1) begin
          mkey[i] = ~mkey[i];
          run[i]  = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.step_pulse === 1'b1) n_pulse++;
    check("duty", bus.duty, m_duty);
    check("step_pulse", bus.step_pulse, m_pulse);
    check("at_max", bus.at_max, (m_duty == MAXD) ? 1 : 0);
    check("at_min", bus.at_min, (m_duty == 0) ? 1 : 0);
  endtask

  int r;
  int len;

  initial begin
    // Reset and a too-short pulse
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_duty", bus.duty, 0);
    check("rst_at_min", bus.at_min, 1);
    check("rst_at_max", bus.at_max, 0);
    check("rst_pulse", bus.step_pulse, 0);
    rst_n = 1'b1;
    press_up = 1'b1;
    repeat (3) tick();
    press_up = 1'b0;
    repeat (15) tick();
    check("glitch_duty", bus.duty, 0);

    // Single press: new duty on the eighth edge
    n_pulse = 0;
    press_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("press_lat_before", bus.duty, 0);
      if (i == 8) check("press_lat_at", bus.duty, 1);
    end
    press_up = 1'b0;
    repeat (40) tick();
    check("single_pulses", n_pulse, 1);

    // Bring duty to 5 with four more presses
    for (int p = 0; p < 4; p++) begin
      press_up = 1'b1;
      repeat (10) tick();
      press_up = 1'b0;
      repeat (20) tick();
    end
    check("five_duty", bus.duty, 5);

    // Auto-repeat downward
    press_dn = 1'b1;
    repeat (58) tick();
    press_dn = 1'b0;
    repeat (20) tick();
`ifdef BRIGHT_WRAP_EN
    check("repeat_end", bus.duty, 15);
`else
    check("repeat_end", bus.duty, 0);
    press_up = 1'b1;
    repeat (150) tick();
    press_up = 1'b0;
    repeat (20) tick();
    check("climb_to_max", bus.duty, 15);
`endif

    // Press up at the top
    n_pulse = 0;
    press_up = 1'b1;
    repeat (10) tick();
    press_up = 1'b0;
    repeat (20) tick();
`ifdef BRIGHT_WRAP_EN
    check("top_duty", bus.duty, 0);
    check("top_pulses", n_pulse, 1);
`else
    check("top_duty", bus.duty, 15);
    check("top_pulses", n_pulse, 0);
`endif

    // Both buttons block further steps
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_pulse = 0;
    press_up = 1'b1;
    repeat (12) tick();
    press_dn = 1'b1;
    repeat (40) tick();
    press_dn = 1'b0;
    repeat (30) tick();
    check("block_pulses", n_pulse, 1);
    press_up = 1'b0;
    repeat (20) tick();
    press_up = 1'b1;
    repeat (10) tick();
    press_up = 1'b0;
    repeat (20) tick();
    check("unblock_duty", bus.duty, 2);
    check("unblock_pulses", n_pulse, 2);

    // Reset while auto-repeating
    press_up = 1'b1;
    repeat (40) tick();
    check("hold_duty", bus.duty, 5);
    rst_n = 1'b0;
    tick();
    check("midrst_duty", bus.duty, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("midrst_before", bus.duty, 0);
      if (i == 8) check("midrst_step", bus.duty, 1);
    end
    press_up = 1'b0;
    repeat (20) tick();

    // Random button activity
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      rst_n    = (r < 2) ? 1'b0 : 1'b1;
      press_up = 1'($urandom_range(0, 1));
      press_dn = ($urandom_range(0, 3) == 0);
      len = (r < 30) ? $urandom_range(1, 6) : $urandom_range(5, 50);
      repeat (len) tick();
    end
    rst_n = 1'b1;
    press_up = 1'b0;
    press_dn = 1'b0;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
